secret_gen: RTL and testbench

SECRET_GEN -- requirements
Module: secret_gen

---
 rtl/secret_gen.sv | 122 ++++++++++++
 tb/tb_secret_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/secret_gen.sv
// rtl/secret_gen.sv - four-digit distinct-BCD secret generator driven by a free-running LFSR
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   rst    : synchronous active-low reset
//   start  : level-sampled request for a new secret (only honoured in IDLE)
//   answer : committed secret, digit1 in [15:12] .. digit4 in [3:0]
//   valid  : answer holds a complete, legal secret
//   busy   : a generation is in progress
//   done   : one-cycle pulse in the cycle a new answer is committed
module secret_gen #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          MAX_TRIES    = 64,
  parameter logic [15:0] RESET_ANSWER = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] answer,
  output logic        valid,
  output logic        busy,
  output logic        done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          TW       = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, DRAW, COMMIT} state_t;

  state_t        state, state_nx;
  logic [15:0]   lfsr;
  logic [1:0]    slot;
  logic [TW-1:0] tries;
  logic [9:0]    used;     // one-hot set of digits accepted in this generation
  logic [15:0]   staging;  // digits shift in from the bottom, first digit ends in [15:12]

  logic [3:0]    cand;
  logic [15:0]   used_ext;
  logic          cand_ok;
  logic          last_try;
  logic          take;
  logic [3:0]    fill;
  logic [3:0]    digit;
  logic          fb;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    cand     = lfsr[3:0];
    used_ext = {6'b0, used};
    cand_ok  = (cand <= 4'd9) && !used_ext[cand];
    last_try = (tries == TW'(MAX_TRIES - 1));
    // Smallest unused digit; at most three are used so one always exists.
    fill = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (!used[i]) fill = 4'(i);
    end
    take  = cand_ok || last_try;
    digit = cand_ok ? cand : fill;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = DRAW;
      DRAW:    if (take && slot == 2'd3) state_nx = COMMIT;
      COMMIT: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      lfsr    <= SEED_EFF;
      answer  <= RESET_ANSWER;
      valid   <= 1'b1;
      busy    <= 1'b0;
      slot    <= 2'd0;
      tries   <= '0;
      used    <= '0;
      staging <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= {lfsr[14:0], fb};
      case (state)
        IDLE: begin
          if (start) begin
            slot  <= 2'd0;
            tries <= '0;
            used  <= '0;
            valid <= 1'b0;
            busy  <= 1'b1;
          end
        end
        DRAW: begin
          if (take) begin
            staging <= {staging[11:0], digit};
            used    <= used | (10'b1 << digit);
            slot    <= slot + 2'd1;
            tries   <= '0;
          end else begin
            tries <= tries + TW'(1);
          end
        end
        COMMIT: begin
          answer <= staging;
          valid  <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secret_gen.sv
// tb/tb_secret_gen.sv - randomized bench for secret_gen against a behavioural generation model
module tb_secret_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] answer_a, answer_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  // Instance a: defaults. Instance b: zero seed and MAX_TRIES=1 so every rejection falls back.
  secret_gen u_a (
    .clk(clk), .rst(rst), .start(start),
    .answer(answer_a), .valid(valid_a), .busy(busy_a), .done(done_a)
  );

  secret_gen #(.SEED(16'h0000), .MAX_TRIES(1)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .answer(answer_b), .valid(valid_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Draws digits by the acceptance rules starting from the LFSR value seen in
  // the first DRAW cycle; returns the secret and the number of DRAW cycles used.
  function automatic void gen(input logic [15:0] l0, input int mt,
                              output logic [15:0] a, output int n);
    int d[$];
    int tries;
    int c;
    bit dup;
    logic [15:0] l;
    l = l0;
    n = 0;
    tries = 0;
    while (d.size() < 4) begin
      c = int'(l[3:0]);
      n++;
      dup = 1'b0;
      foreach (d[i]) if (d[i] == c) dup = 1'b1;
      if (c <= 9 && !dup) begin
        d.push_back(c);
        tries = 0;
      end else if (tries == mt - 1) begin
        for (int v = 0; v < 10; v++) begin
          bit u;
          u = 1'b0;
          foreach (d[i]) if (d[i] == v) u = 1'b1;
          if (!u) begin
            d.push_back(v);
            break;
          end
        end
        tries = 0;
      end else begin
        tries++;
      end
      l = step(l);
    end
    a = 16'(d[0] * 4096 + d[1] * 256 + d[2] * 16 + d[3]);
  endfunction

  function automatic bit legal(input logic [15:0] a);
    bit [15:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'((a >> (4 * i)) & 16'hF);
      if (v > 9 || seen[v]) return 1'b0;
      seen[v] = 1'b1;
    end
    return 1'b1;
  endfunction

  localparam logic [15:0] M_SEED [2] = '{16'hACE1, 16'h0001};
  localparam int          M_MT   [2] = '{64, 1};

  logic [15:0] m_lfsr [2];
  logic [15:0] m_ans  [2];
  logic [15:0] m_pend [2];
  bit          m_valid[2], m_busy[2], m_done[2], m_active[2];
  int          m_left [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_lfsr[k]   = M_SEED[k];
        m_ans[k]    = 16'h1234;
        m_valid[k]  = 1'b1;
        m_busy[k]   = 1'b0;
        m_done[k]   = 1'b0;
        m_active[k] = 1'b0;
        m_left[k]   = 0;
      end else begin
        logic [15:0] nx;
        nx = step(m_lfsr[k]);
        if (m_done[k]) begin
          m_ans[k]    = m_pend[k];
          m_valid[k]  = 1'b1;
          m_busy[k]   = 1'b0;
          m_done[k]   = 1'b0;
          m_active[k] = 1'b0;
        end else if (m_active[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) m_done[k] = 1'b1;
        end else if (start) begin
          gen(nx, M_MT[k], m_pend[k], m_left[k]);
          m_active[k] = 1'b1;
          m_valid[k]  = 1'b0;
          m_busy[k]   = 1'b1;
        end
        m_lfsr[k] = nx;
      end
    end
  end

  task automatic check_all();
    logic [15:0] ans, lf;
    logic        v, b, d;
    for (int k = 0; k < 2; k++) begin
      ans = (k == 0) ? answer_a : answer_b;
      v   = (k == 0) ? valid_a  : valid_b;
      b   = (k == 0) ? busy_a   : busy_b;
      d   = (k == 0) ? done_a   : done_b;
      lf  = (k == 0) ? u_a.lfsr : u_b.lfsr;
      check($sformatf("answer%0d", k), 32'(ans), 32'(m_ans[k]));
      check($sformatf("valid%0d", k), 32'(v), 32'(m_valid[k]));
      check($sformatf("busy%0d", k), 32'(b), 32'(m_busy[k]));
      check($sformatf("done%0d", k), 32'(d), 32'(m_done[k]));
      check($sformatf("lfsr%0d", k), 32'(lf), 32'(m_lfsr[k]));
      if (m_valid[k]) check($sformatf("legal%0d", k), 32'(legal(ans)), 32'd1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    repeat (2) tick();
    check("reset_answer", 32'(answer_a), 32'h1234);
    check("reset_lfsr_zero_seed", 32'(u_b.lfsr), 32'h0001);

    rst   = 1'b1;
    start = 1'b0;
    repeat (20) tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("midraw_reset_lfsr", 32'(u_a.lfsr), 32'hACE1);
    rst = 1'b1;
    repeat (20) tick();

    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1;

    start = 1'b1;
    repeat (1000) tick();
    start = 1'b0;
    repeat (300) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
